// File: rtl/parity_stream_checker_if.sv
// Bundles the word stream, its parity/mode qualifiers, the clear strobe and the checker results.
// The master drives words; the slave, the checker, returns status.
interface parity_stream_checker_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] data;
    logic              p;
    logic              odd_mode;
    logic              clr;
    logic              out_valid;
    logic              error;
    logic [CNT_W-1:0]  err_count;
    logic              err_sticky;
    logic              alarm;

    modport master (
        output in_valid, data, p, odd_mode, clr,
        input  out_valid, error, err_count, err_sticky, alarm
    );

    modport slave (
        input  in_valid, data, p, odd_mode, clr,
        output out_valid, error, err_count, err_sticky, alarm
    );
endinterface

// File: rtl/parity_stream_checker.sv
// Streaming parity checker with a registered per-word error, a saturating error count,
// a sticky flag and a burst alarm that locks after LOCK_N consecutive bad words.
module parity_stream_checker #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    parity_stream_checker_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        LOCK  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LOCK_VAL = CNT_W'(LOCK_N);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] run_reg, run_next;
    logic [CNT_W-1:0] err_count_reg, err_count_next;
    logic             err_sticky_reg, err_sticky_next;
    logic             out_valid_reg, error_reg, alarm_reg;

    // XOR chain seeded with the received parity bit: high when popcount(data)+p is odd.
    logic [DATA_W:0] par_chain;
    assign par_chain[0] = bus.p;
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_par
            assign par_chain[gi+1] = par_chain[gi] ^ bus.data[gi];
        end
    endgenerate

    logic ones_odd, bad, bad_word;
    assign ones_odd = par_chain[DATA_W];
    // Odd mode wants an odd total, even mode an even total.
    assign bad      = ones_odd ^ bus.odd_mode;
    assign bad_word = bus.in_valid & bad;

    always_comb begin
        state_next      = state_reg;
        run_next        = run_reg;
        err_count_next  = err_count_reg;
        err_sticky_next = err_sticky_reg;

        if (bus.clr) begin
            state_next      = IDLE;
            run_next        = '0;
            err_count_next  = '0;
            err_sticky_next = 1'b0;
        end else begin
            if (bad_word) begin
                err_sticky_next = 1'b1;
                if (err_count_reg != '1) begin
                    err_count_next = err_count_reg + CNT_W'(1);
                end
            end

            case (state_reg)
                IDLE: begin
                    if (bad_word) begin
                        run_next   = CNT_W'(1);
                        state_next = (LOCK_VAL == CNT_W'(1)) ? LOCK : BURST;
                    end
                end
                BURST: begin
                    if (bad_word) begin
                        run_next = run_reg + CNT_W'(1);
                        if (run_reg + CNT_W'(1) >= LOCK_VAL) begin
                            run_next   = LOCK_VAL;
                            state_next = LOCK;
                        end
                    end else if (bus.in_valid) begin
                        run_next   = '0;
                        state_next = IDLE;
                    end
                end
                LOCK: begin
                    state_next = LOCK;
                end
                default: begin
                    state_next = IDLE;
                    run_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            run_reg        <= '0;
            err_count_reg  <= '0;
            err_sticky_reg <= 1'b0;
            out_valid_reg  <= 1'b0;
            error_reg      <= 1'b0;
            alarm_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            run_reg        <= run_next;
            err_count_reg  <= err_count_next;
            err_sticky_reg <= err_sticky_next;
            out_valid_reg  <= bus.in_valid;
            // The word's own error is reported even when clr suppresses its counting.
            error_reg      <= bad_word;
            alarm_reg      <= (state_next == LOCK);
        end
    end

    assign bus.out_valid  = out_valid_reg;
    assign bus.error      = error_reg;
    assign bus.err_count  = err_count_reg;
    assign bus.err_sticky = err_sticky_reg;
    assign bus.alarm      = alarm_reg;
endmodule

// File: tb/tb_parity_stream_checker.sv
// Self-checking bench: a behavioural model pushes expected outputs per driven cycle,
// which are popped and compared one cycle later.
module tb_parity_stream_checker;
    localparam int DATA_W = 4;
    localparam int CNT_W  = 3;
    localparam int LOCK_N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    parity_stream_checker_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    parity_stream_checker #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W),
        .LOCK_N(LOCK_N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic ov;
        logic err;
        int   cnt;
        logic sticky;
        logic alarm;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad_n = 0;

    int   m_cnt = 0;
    logic m_sticky = 1'b0;
    int   m_run = 0;
    logic m_locked = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_sticky = 1'b0; m_run = 0; m_locked = 1'b0;
        sb.delete();
    endtask

    // Called just after a falling edge: drive one cycle, model it, then compare after the rising edge.
    task automatic cycle(input string tag, input logic v, input logic [3:0] d,
                         input logic pp, input logic odd, input logic c);
        exp_t e;
        int   ones;
        logic is_bad;
        bus.in_valid = v; bus.data = d; bus.p = pp; bus.odd_mode = odd; bus.clr = c;
        ones   = $countones(d) + int'(pp);
        is_bad = odd ? (ones % 2 == 0) : (ones % 2 == 1);
        if (c) begin
            m_cnt = 0; m_sticky = 1'b0; m_run = 0; m_locked = 1'b0;
        end else if (v) begin
            if (is_bad) begin
                if (m_cnt < 7) m_cnt++;
                m_sticky = 1'b1;
                if (!m_locked) begin
                    m_run++;
                    if (m_run >= LOCK_N) m_locked = 1'b1;
                end
            end else if (!m_locked) begin
                m_run = 0;
            end
        end
        e.ov = v; e.err = v & is_bad; e.cnt = m_cnt; e.sticky = m_sticky; e.alarm = m_locked;
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".ov"},     int'(bus.out_valid),  int'(e.ov));
        check({tag, ".err"},    int'(bus.error),      int'(e.err));
        check({tag, ".cnt"},    int'(bus.err_count),  e.cnt);
        check({tag, ".sticky"}, int'(bus.err_sticky), int'(e.sticky));
        check({tag, ".alarm"},  int'(bus.alarm),      int'(e.alarm));
        $display("txn %s v=%0d d=%b p=%0d odd=%0d clr=%0d -> ov=%0d err=%0d cnt=%0d sticky=%0d alarm=%0d",
                 tag, v, d, pp, odd, c, bus.out_valid, bus.error, bus.err_count,
                 bus.err_sticky, bus.alarm);
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic clear(input string tag);
        cycle(tag, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.data = '0; bus.p = 1'b0; bus.odd_mode = 1'b1; bus.clr = 1'b0;
        #1;
        check("rst.ov",     int'(bus.out_valid),  0);
        check("rst.err",    int'(bus.error),      0);
        check("rst.cnt",    int'(bus.err_count),  0);
        check("rst.sticky", int'(bus.err_sticky), 0);
        check("rst.alarm",  int'(bus.alarm),      0);
        @(negedge clk);
        rst = 1'b0;

        // 1: odd mode back-to-back
        cycle("t1w0", 1'b1, 4'b0101, 1'b0, 1'b1, 1'b0);
        cycle("t1w1", 1'b1, 4'b1101, 1'b1, 1'b1, 1'b0);
        cycle("t1w2", 1'b1, 4'b0111, 1'b0, 1'b1, 1'b0);
        cycle("t1w3", 1'b1, 4'b1001, 1'b1, 1'b1, 1'b0);
        check("t1.cnt_abs", int'(bus.err_count), 2);
        check("t1.alarm_abs", int'(bus.alarm), 0);

        // 2: even mode
        clear("t2clr");
        cycle("t2w0", 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0);
        cycle("t2w1", 1'b1, 4'b0111, 1'b0, 1'b0, 1'b0);
        check("t2.cnt_abs", int'(bus.err_count), 1);

        // 3: three bad words separated by gaps lock the alarm
        clear("t3clr");
        for (int i = 0; i < 3; i++) begin
            cycle("t3bad", 1'b1, 4'b0101, 1'b0, 1'b1, 1'b0);
            if (i < 2) begin
                idle("t3gap");
                idle("t3gap");
            end
        end
        check("t3.alarm_abs", int'(bus.alarm), 1);
        cycle("t3good", 1'b1, 4'b0111, 1'b0, 1'b1, 1'b0);
        cycle("t3good", 1'b1, 4'b1000, 1'b0, 1'b1, 1'b0);
        clear("t3clr2");
        check("t3.alarm_clr", int'(bus.alarm), 0);

        // 4: 2 bad, 1 good, 2 bad
        for (int i = 0; i < 5; i++) begin
            if (i == 2) cycle("t4good", 1'b1, 4'b0001, 1'b0, 1'b1, 1'b0);
            else        cycle("t4bad",  1'b1, 4'b0011, 1'b0, 1'b1, 1'b0);
        end
        check("t4.cnt_abs", int'(bus.err_count), 4);

        // 5: saturation
        clear("t5clr");
        for (int i = 0; i < 10; i++) cycle("t5bad", 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
        check("t5.cnt_abs", int'(bus.err_count), 7);

        // 6: clr with a bad word, then async reset mid-burst
        cycle("t6clrbad", 1'b1, 4'b0101, 1'b0, 1'b1, 1'b1);
        check("t6.cnt_abs", int'(bus.err_count), 0);
        cycle("t6bad", 1'b1, 4'b0101, 1'b0, 1'b1, 1'b0);
        cycle("t6bad", 1'b1, 4'b0101, 1'b0, 1'b1, 1'b0);
        bus.in_valid = 1'b1; bus.data = 4'b0101; bus.p = 1'b0; bus.odd_mode = 1'b1; bus.clr = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst.ov",     int'(bus.out_valid),  0);
        check("arst.err",    int'(bus.error),      0);
        check("arst.cnt",    int'(bus.err_count),  0);
        check("arst.sticky", int'(bus.err_sticky), 0);
        check("arst.alarm",  int'(bus.alarm),      0);
        @(posedge clk);
        #1;
        check("arst.ov_hold", int'(bus.out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle("post", 1'b1, 4'b0111, 1'b0, 1'b1, 1'b0);
        cycle("post", 1'b1, 4'b0110, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad_n);
        $finish;
    end
endmodule
